mem_arbiter: RTL

//  Shares the single main-memory port between the I-cache fill path and the D-cache

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Main-memory arbiter shared by the I-cache fill path and the D-cache
// fill/writeback path; D side wins unless the I side has waited too long.
module mem_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int LINE_W       = 64,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [LINE_W-1:0] d_rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_rdy,
   output logic              err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
   localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY,
      DONE
   } state_t;

   state_t        state;
   logic [SW-1:0] streak;
   logic [7:0]    timer;
   logic          d_win;

   // D wins unless the I side has already been passed over STARVE_LIMIT times
   assign d_win = d_req && !(i_req && streak == LIMIT);

   // Arbitration FSM; every output is a register updated here
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         timer     <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (d_win) begin
                  state     <= D_BUSY;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_we    <= d_we;
                  mem_re    <= ~d_we;
                  timer     <= '0;
                  if (!i_req)
                     streak <= '0;
                  else if (streak != LIMIT)
                     streak <= streak + 1'b1;
               end else if (i_req) begin
                  state    <= I_BUSY;
                  mem_addr <= i_addr;
                  mem_re   <= 1'b1;
                  mem_we   <= 1'b0;
                  timer    <= '0;
                  streak   <= '0;
               end
            end
            I_BUSY, D_BUSY: begin
               if (mem_rdy) begin
                  state  <= DONE;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  if (state == I_BUSY) begin
                     i_rdata <= mem_rdata;
                     i_ack   <= 1'b1;
                  end else begin
                     if (!mem_we)
                        d_rdata <= mem_rdata;
                     d_ack <= 1'b1;
                  end
               end else if (timer == TMAX) begin
                  // memory never answered: abort with a zero line
                  state  <= DONE;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
                  err    <= 1'b1;
                  if (state == I_BUSY) begin
                     i_rdata <= '0;
                     i_ack   <= 1'b1;
                  end else begin
                     d_rdata <= '0;
                     d_ack   <= 1'b1;
                  end
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
